bcd_seq_shifter: RTL
====================

# bcd_seq_shifter

Sequential, parametrised BCD digit shifter for the RPN calculator datapath. It shifts an `NUM_DIGITS`-digit packed BCD operand left or right by a run-time digit count, one digit per clock, and fills vacated positions with a supplied digit. Right shifts also report the guard digit and a sticky flag for rounding; left shifts report digit overflow. It sits between the operand registers and the add/sub/mul/div units as the shared alignment and normalisation engine, controlled by a start/busy/done handshake.

## Interface
- `NUM_DIGITS`, default 8: operand width in BCD digits; must be ≥ 2.
- `AMT_W`, default `$clog2(NUM_DIGITS+1)`: shift-amount width, so that a full-width shift is encodable.
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_dir`  in  1  0 = right shift (toward LSD), 1 = left shift (toward MSD).
- `i_num`  in  NUM_DIGITS*4  packed BCD operand; MSD is at the top bits.
- `i_fill`  in  4  digit inserted into each vacated position.
- `i_amt`  in  AMT_W  shift distance in digits.
- `o_num`  out  NUM_DIGITS*4  shifted result.
- `o_guard`  out  4  right shift: the last digit shifted out. Left shift: 0.
- `o_sticky`  out  1  right shift: 1 if any digit shifted out before the guard digit is nonzero. Left shift: 0.
- `o_ovf`  out  1  left shift: 1 if any digit shifted out is nonzero. Right shift: 0.
- `o_err`  out  1  1 if any digit of `i_num` or `i_fill` captured at start is greater than 9.
- `o_busy`  out  1  high in SHIFT and DONE.
- `o_done`  out  1  single-cycle pulse; results are valid from this cycle.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with `i_start`=1:
  - Capture `i_num` into the working register.
  - Capture `i_dir` and `i_fill`.
  - Set the counter to min(`i_amt`, `NUM_DIGITS`). Amounts above `NUM_DIGITS` saturate.
  - Clear guard, sticky and ovf.
  - Compute `o_err` from the captured digits.
  - Next state is SHIFT if the clamped amount is greater than 0, otherwise DONE.
- SHIFT, each cycle:
  - Right shift:
    - The working register becomes {fill, reg[top:1 digit]}.
    - sticky |= (guard ≠ 0).
    - guard ← the digit shifted out (the old LSD).
  - Left shift:
    - The working register becomes {reg[lower digits], fill}.
    - ovf |= (the old MSD ≠ 0).
  - Decrement the counter. When it was 1, the next state is DONE.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Outputs hold their last values in IDLE until the next accepted start.
- `i_start` outside IDLE is ignored. There is no queueing.
- Input digits greater than 9 are shifted verbatim. Only `o_err` flags them.
- Synchronous reset in any state:
  - Return to IDLE.
  - Drive `o_num`=0, `o_guard`=0, `o_sticky`=0, `o_ovf`=0, `o_err`=0, `o_busy`=0, `o_done`=0.
  - Any shift in progress is abandoned with no done pulse.
- When reset and start are both high, reset wins.

## Timing
- Start accepted at edge t. `o_busy`=1 from cycle t+1.
- With clamped amount n > 0: SHIFT occupies cycles t+1 … t+n, and `o_done` is asserted in cycle t+n+1.
- With n = 0: `o_done` is asserted in cycle t+1, and `o_num` equals `i_num`.
- `o_busy` falls in the cycle after DONE. A new start is accepted at that edge at the earliest, giving a throughput of one operation per n+2 cycles.
- Inputs are don't-care except at the accepting edge.

## Test plan
- NUM_DIGITS=4:
  - Right shift of 0x1234 by 2, fill 0: done 3 cycles after start; `o_num`=0x0012, guard=3, sticky=1, ovf=0, err=0.
  - Left shift of 0x1234 by 1, fill 9: done at cycle t+2; `o_num`=0x2349, ovf=1, guard=0, sticky=0.
  - Left shift of 0x0012 by 2: `o_num`=0x1200, ovf=0.
  - amt=0 and amt=7 (clamped to 4):
    - Right shift of 0x5000 by 0: done at t+1, `o_num`=0x5000.
    - Right shift of 0x5000 by 7: done at t+5, `o_num`=0x0000, guard=5, sticky=0.
  - Handshake and reset:
    - Assert start again while busy: no effect; exactly one done pulse.
    - Assert `i_rst` in the middle of SHIFT: all outputs 0 on the next cycle, and no done pulse.
  - Input digit 0xA in `i_num` (0x1A34, right shift by 1): `o_err`=1; `o_num`=0x01A3, guard=4.

Source files
------------

// File: rtl/bcd_seq_shifter.sv
// Sequential BCD digit shifter: moves a packed BCD operand left or right by a
// run-time digit count, one digit per clock, with guard/sticky/overflow reporting.
module bcd_seq_shifter #(
   parameter int NUM_DIGITS = 8,
   parameter int AMT_W      = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_dir,
   input  logic [NUM_DIGITS*4-1:0] i_num,
   input  logic [3:0]              i_fill,
   input  logic [AMT_W-1:0]        i_amt,
   output logic [NUM_DIGITS*4-1:0] o_num,
   output logic [3:0]              o_guard,
   output logic                    o_sticky,
   output logic                    o_ovf,
   output logic                    o_err,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int W = NUM_DIGITS * 4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     num_q, num_d;
   logic             dir_q, dir_d;
   logic [3:0]       fill_q, fill_d;
   logic [3:0]       guard_q, guard_d;
   logic             sticky_q, sticky_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;

   logic [AMT_W-1:0] amtClamp;
   logic             startErr;

   // Shift distance saturates at the operand width; any non-BCD digit raises err.
   always_comb begin
      amtClamp = (i_amt > AMT_W'(NUM_DIGITS)) ? AMT_W'(NUM_DIGITS) : i_amt;
      startErr = (i_fill > 4'd9);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (i_num[k*4 +: 4] > 4'd9) begin
            startErr = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         num_q    <= '0;
         dir_q    <= 1'b0;
         fill_q   <= '0;
         guard_q  <= '0;
         sticky_q <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         dir_q    <= dir_d;
         fill_q   <= fill_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      dir_d    = dir_q;
      fill_d   = fill_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               num_d    = i_num;
               dir_d    = i_dir;
               fill_d   = i_fill;
               guard_d  = '0;
               sticky_d = 1'b0;
               ovf_d    = 1'b0;
               err_d    = startErr;
               cnt_d    = amtClamp;
               state_d  = (amtClamp != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // Sticky collects the previous guard before the new digit falls out.
            if (dir_q) begin
               num_d = {num_q[W-5:0], fill_q};
               ovf_d = ovf_q | (num_q[W-1 -: 4] != 4'd0);
            end else begin
               num_d    = {fill_q, num_q[W-1:4]};
               sticky_d = sticky_q | (guard_q != 4'd0);
               guard_d  = num_q[3:0];
            end
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_num    = num_q;
   assign o_guard  = guard_q;
   assign o_sticky = sticky_q;
   assign o_ovf    = ovf_q;
   assign o_err    = err_q;
   assign o_busy   = (state_q != IDLE);
   assign o_done   = (state_q == DONE);

endmodule
